hls_fp17_mul_chn_a_skid: RTL and testbench
==========================================

HLS_FP17_MUL_CHN_A_SKID -- requirements
Module: hls_fp17_mul_chn_a_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 17, payload width of one fp17 operand.
REQ-002 SHALL have parameter CNTW, default 16, width of the transfer counter.
REQ-003 SHALL have port nvdla_core_clk, input, 1, the single clock; all flops rise-edge.
REQ-004 SHALL have port nvdla_core_rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port chn_a_in_pd, input, WIDTH, producer payload.
REQ-006 SHALL have port chn_a_in_valid, input, 1, producer payload valid.
REQ-007 SHALL have port chn_a_in_prdy, output, 1, ready to producer, driven only from flops.
REQ-008 SHALL have port chn_a_rsc_z, output, WIDTH, operand to the fp17 mul channel-a input wire.
REQ-009 SHALL have port chn_a_rsc_vz, output, 1, operand valid to the channel-a input wire.
REQ-010 SHALL have port chn_a_rsc_lz, input, 1, load strobe from the channel-a input wire (consume).
REQ-011 SHALL have port occ, output, 2, current entry count (0..2).
REQ-012 SHALL have port xfer_cnt, output, CNTW, count of operands delivered downstream.

Function
REQ-013 SHALL be a 2-entry FIFO: entry array, 1-bit write pointer, 1-bit read pointer, 2-bit occupancy register.
REQ-014 SHALL define push = chn_a_in_valid & chn_a_in_prdy, evaluated at the clock edge.
REQ-015 SHALL define pop = chn_a_rsc_vz & chn_a_rsc_lz; chn_a_rsc_lz with chn_a_rsc_vz low SHALL have no effect.
REQ-016 SHALL drive chn_a_in_prdy = (occ != 2), occupancy flops only, no combinational path from chn_a_rsc_lz.
REQ-017 SHALL drive chn_a_rsc_vz = (occ != 0) and chn_a_rsc_z = entry at read pointer; chn_a_rsc_z is a don't-care when vz low but SHALL hold the last value (no X).
REQ-018 SHALL write chn_a_in_pd into the write-pointer entry and toggle the write pointer on push.
REQ-019 SHALL toggle the read pointer on pop.
REQ-020 SHALL update occ: push only +1, pop only -1, push and pop together unchanged.
REQ-021 Full (occ=2): prdy low, push impossible; a pop the same cycle raises prdy the next cycle, not the same cycle.
REQ-022 Empty (occ=0): vz low; a push becomes visible on vz/z the next cycle (latency 1, no bypass).
REQ-023 Simultaneous push and pop at occ=1 SHALL deliver the head and capture the new word with no bubble; throughput 1 operand/cycle when downstream lz held high.
REQ-024 SHALL preserve ordering; no payload SHALL be dropped or duplicated.
REQ-025 SHALL increment xfer_cnt by 1 on each pop, wrapping from 2^CNTW-1 to 0.
REQ-026 chn_a_in_pd changing while chn_a_in_valid is low or prdy is low SHALL not affect stored entries.

Reset
REQ-027 On nvdla_core_rst high, SHALL asynchronously clear pointers, occ, xfer_cnt: chn_a_rsc_vz=0, chn_a_in_prdy=1, occ=0, xfer_cnt=0.
REQ-028 Entry payload registers SHALL reset to 0, so chn_a_rsc_z=0 during and after reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; no pop or push is counted in the reset cycle.
REQ-030 After reset deassertion, first push SHALL be accepted on the first clock edge with rst low.

Verification
REQ-031 Single word: reset, push 0x1ABCD with lz=0 -> next cycle vz=1, z=0x1ABCD, occ=1; lz=1 one cycle -> vz=0, xfer_cnt=1.
REQ-032 Fill/stall: push 0x00001, 0x00002 with lz=0 -> occ=2, prdy=0; valid held with 0x00003 not accepted; lz=1 one cycle -> z=0x00002 next, prdy=1 next cycle, 0x00003 accepted after.
REQ-033 Streaming: valid=1 and lz=1 continuously, 100 incrementing words -> 100 words out in order, one per cycle after 1-cycle latency, xfer_cnt=100.
REQ-034 Spurious load: occ=0, lz=1 for 5 cycles -> xfer_cnt unchanged, occ stays 0.
REQ-035 Wrap: force 2^16 pops with CNTW=16 -> xfer_cnt returns to 0; pointers wrap with ordering intact.
REQ-036 Mid-operation reset: occ=2, assert rst asynchronously between edges -> vz=0, prdy=1, occ=0, z=0 immediately; after release, new word 0x0FFFF delivered first.

Source files
------------

// File: rtl/hls_fp17_mul_chn_a_skid.sv
// Two-entry skid FIFO feeding the fp17 multiplier channel-a operand wire.
// Ready and valid decode the occupancy flops only; lz never reaches prdy combinationally.
module hls_fp17_mul_chn_a_skid #(
   parameter int WIDTH = 17,
   parameter int CNTW  = 16
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rst,
   input  logic [WIDTH-1:0] chn_a_in_pd,
   input  logic             chn_a_in_valid,
   output logic             chn_a_in_prdy,
   output logic [WIDTH-1:0] chn_a_rsc_z,
   output logic             chn_a_rsc_vz,
   input  logic             chn_a_rsc_lz,
   output logic [1:0]       occ,
   output logic [CNTW-1:0]  xfer_cnt
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_occ;
   logic [CNTW-1:0]  r_cnt;

   logic             w_push;
   logic             w_pop;
   logic             w_rd_idx;

   assign chn_a_in_prdy = (r_occ != 2'd2);
   assign chn_a_rsc_vz  = (r_occ != 2'd0);
   assign w_push        = chn_a_in_valid & chn_a_in_prdy;
   assign w_pop         = chn_a_rsc_vz & chn_a_rsc_lz;

   // When empty, show the most recently delivered entry so z holds its last value.
   assign w_rd_idx      = (r_occ == 2'd0) ? ~r_rptr : r_rptr;
   assign chn_a_rsc_z   = r_mem[w_rd_idx];

   assign occ           = r_occ;
   assign xfer_cnt      = r_cnt;

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_occ  <= 2'd0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= chn_a_in_pd;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
            r_cnt  <= r_cnt + CNTW'(1);
         end
         if (w_push && !w_pop) begin
            r_occ <= r_occ + 2'd1;
         end else if (w_pop && !w_push) begin
            r_occ <= r_occ - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_hls_fp17_mul_chn_a_skid.sv
// Directed bench for the channel-a skid FIFO: vector table plus streaming, wrap and reset sequences.
module tb_hls_fp17_mul_chn_a_skid;

   logic        clk;
   logic        rst;
   logic [16:0] pd;
   logic        valid;
   logic        prdy;
   logic [16:0] z;
   logic        vz;
   logic        lz;
   logic [1:0]  occ;
   logic [15:0] cnt;

   int n_vec;
   int n_bad;

   typedef struct {
      logic        v;
      logic [16:0] pd;
      logic        lz;
      logic        prdy;
      logic        vz;
      logic [16:0] z;
      logic [1:0]  occ;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl [17];

   hls_fp17_mul_chn_a_skid #(.WIDTH(17), .CNTW(16)) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .chn_a_in_pd    (pd),
      .chn_a_in_valid (valid),
      .chn_a_in_prdy  (prdy),
      .chn_a_rsc_z    (z),
      .chn_a_rsc_vz   (vz),
      .chn_a_rsc_lz   (lz),
      .occ            (occ),
      .xfer_cnt       (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all(input string name, input logic e_prdy, input logic e_vz,
                            input logic [16:0] e_z, input logic [1:0] e_occ, input logic [15:0] e_cnt);
      n_vec++;
      if ({prdy, vz, z, occ, cnt} !== {e_prdy, e_vz, e_z, e_occ, e_cnt}) begin
         n_bad++;
         $display("FAIL %s: got prdy=%b vz=%b z=%h occ=%0d cnt=%0d, want prdy=%b vz=%b z=%h occ=%0d cnt=%0d",
                  name, prdy, vz, z, occ, cnt, e_prdy, e_vz, e_z, e_occ, e_cnt);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = 1'b0;
      lz = 1'b0;
      pd = '0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic stream(input string name, input int n);
      valid = 1'b1;
      lz = 1'b1;
      for (int i = 0; i < n; i++) begin
         pd = 17'(i);
         cyc();
         n_vec++;
         if (vz !== 1'b1 || z !== 17'(i)) begin
            n_bad++;
            $display("FAIL %s word %0d: got vz=%b z=%h, want vz=1 z=%h", name, i, vz, z, 17'(i));
         end
      end
      valid = 1'b0;
      cyc();
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;

      //            v   pd          lz   prdy vz  z           occ   cnt
      tbl[0]  = '{1'b1, 17'h1ABCD, 1'b0, 1'b1, 1'b1, 17'h1ABCD, 2'd1, 16'd0};
      tbl[1]  = '{1'b0, 17'h00000, 1'b1, 1'b1, 1'b0, 17'h1ABCD, 2'd0, 16'd1};
      tbl[2]  = '{1'b1, 17'h00001, 1'b0, 1'b1, 1'b1, 17'h00001, 2'd1, 16'd1};
      tbl[3]  = '{1'b1, 17'h00002, 1'b0, 1'b0, 1'b1, 17'h00001, 2'd2, 16'd1};
      tbl[4]  = '{1'b1, 17'h15555, 1'b0, 1'b0, 1'b1, 17'h00001, 2'd2, 16'd1};
      tbl[5]  = '{1'b1, 17'h00003, 1'b1, 1'b1, 1'b1, 17'h00002, 2'd1, 16'd2};
      tbl[6]  = '{1'b1, 17'h00003, 1'b0, 1'b0, 1'b1, 17'h00002, 2'd2, 16'd2};
      tbl[7]  = '{1'b0, 17'h1FFFF, 1'b1, 1'b1, 1'b1, 17'h00003, 2'd1, 16'd3};
      tbl[8]  = '{1'b0, 17'h1FFFF, 1'b1, 1'b1, 1'b0, 17'h00003, 2'd0, 16'd4};
      tbl[9]  = '{1'b0, 17'h0AAAA, 1'b1, 1'b1, 1'b0, 17'h00003, 2'd0, 16'd4};
      tbl[10] = '{1'b0, 17'h15555, 1'b1, 1'b1, 1'b0, 17'h00003, 2'd0, 16'd4};
      tbl[11] = '{1'b0, 17'h00F0F, 1'b1, 1'b1, 1'b0, 17'h00003, 2'd0, 16'd4};
      tbl[12] = '{1'b0, 17'h1F0F0, 1'b1, 1'b1, 1'b0, 17'h00003, 2'd0, 16'd4};
      tbl[13] = '{1'b0, 17'h12345, 1'b1, 1'b1, 1'b0, 17'h00003, 2'd0, 16'd4};
      tbl[14] = '{1'b1, 17'h0000A, 1'b0, 1'b1, 1'b1, 17'h0000A, 2'd1, 16'd4};
      tbl[15] = '{1'b1, 17'h0000B, 1'b1, 1'b1, 1'b1, 17'h0000B, 2'd1, 16'd5};
      tbl[16] = '{1'b0, 17'h00000, 1'b1, 1'b1, 1'b0, 17'h0000B, 2'd0, 16'd6};

      rst = 1'b1;
      valid = 1'b0;
      lz = 1'b0;
      pd = 17'h1FFFF;
      #1;
      check_all("reset_async", 1'b1, 1'b0, 17'h0, 2'd0, 16'd0);
      @(negedge clk);
      cyc();
      check_all("reset_hold", 1'b1, 1'b0, 17'h0, 2'd0, 16'd0);
      rst = 1'b0;

      // Single word, fill/stall, spurious loads, push+pop at occ=1.
      for (int i = 0; i < 17; i++) begin
         valid = tbl[i].v;
         pd    = tbl[i].pd;
         lz    = tbl[i].lz;
         cyc();
         check_all($sformatf("vec%0d", i), tbl[i].prdy, tbl[i].vz, tbl[i].z, tbl[i].occ, tbl[i].cnt);
      end
      lz = 1'b0;

      // Streaming 100 words, one per cycle.
      do_reset();
      stream("stream", 100);
      check_all("stream_end", 1'b1, 1'b0, 17'd99, 2'd0, 16'd100);

      // Full 2^16 pops: counter wraps back to zero.
      do_reset();
      stream("wrap", 65536);
      check_all("wrap_end", 1'b1, 1'b0, 17'hFFFF, 2'd0, 16'd0);

      // Mid-operation asynchronous reset with the FIFO full.
      lz = 1'b0;
      valid = 1'b1;
      pd = 17'h00011;
      cyc();
      pd = 17'h00022;
      cyc();
      valid = 1'b0;
      check_all("pre_rst_full", 1'b0, 1'b1, 17'h00011, 2'd2, 16'd0);
      #2;
      rst = 1'b1;
      #1;
      check_all("midop_rst", 1'b1, 1'b0, 17'h0, 2'd0, 16'd0);
      @(negedge clk);
      lz = 1'b1;
      valid = 1'b1;
      pd = 17'h1EEEE;
      cyc();
      check_all("rst_blocks_ops", 1'b1, 1'b0, 17'h0, 2'd0, 16'd0);
      rst = 1'b0;
      lz = 1'b0;
      pd = 17'h0FFFF;
      cyc();
      valid = 1'b0;
      check_all("post_rst_first", 1'b1, 1'b1, 17'h0FFFF, 2'd1, 16'd0);
      lz = 1'b1;
      cyc();
      check_all("post_rst_pop", 1'b1, 1'b0, 17'h0FFFF, 2'd0, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
